// File: rtl/sdram_accel_sequencer.sv
// sdram_accel_sequencer
// ---------------------
// Converts one accelerator burst request into an SDRAM bus-ownership
// handshake plus the command sequence ACTIVE, READ/WRITE, BURST TERMINATE,
// PRECHARGE ALL. It then releases the bus. The device is assumed to be
// running the camera mode register (CAS latency 3, full-page burst) while
// the accelerator owns the bus.
//
// Ports
//   clk, Reset_N           clock; asynchronous active-low reset
//   AccelHasControl        arbiter grant (input)
//   RequestAccelControl    ownership request to the arbiter
//   start/wr/bank/row/col/len   request; len=0 encodes 256 words
//   busy, done, err        status; err qualifies done (grant lost)
//   wdata, wreq            write word, consumed in every wreq cycle
//   rdata, rvalid          registered read word stream
//   dq_in, dq_out, dq_oe   SDRAM data pins
//   *_accel                SDRAM command bus toward the arbiter mux
//   state_dbg              current FSM state, for observation only
//
// Handshakes: start is taken only in a cycle where busy=0, and busy stays
// high until the done pulse. wreq means "wdata is consumed this cycle", so
// the source must present the next word in that same cycle. rvalid marks a
// valid rdata for exactly one cycle and cannot be stalled.
//
// All command-bus and status outputs come straight from flops. Each one is
// computed from the next state, so the arbiter mux sees glitch-free values.
module sdram_accel_sequencer #(
    parameter int T_RCD   = 2,
    parameter int T_RP    = 2,
    parameter int CAS_LAT = 3
) (
    input  logic        clk,
    input  logic        Reset_N,
    input  logic        AccelHasControl,
    output logic        RequestAccelControl,
    input  logic        start,
    input  logic        wr,
    input  logic [1:0]  bank,
    input  logic [11:0] row,
    input  logic [7:0]  col,
    input  logic [7:0]  len,
    output logic        busy,
    output logic        done,
    output logic        err,
    input  logic [15:0] wdata,
    output logic        wreq,
    output logic [15:0] rdata,
    output logic        rvalid,
    input  logic [15:0] dq_in,
    output logic [15:0] dq_out,
    output logic        dq_oe,
    output logic [11:0] SA_accel,
    output logic [1:0]  BA_accel,
    output logic [1:0]  CS_N_accel,
    output logic        CKE_accel,
    output logic        RAS_N_accel,
    output logic        CAS_N_accel,
    output logic        WE_N_accel,
    output logic [1:0]  DQM_accel,
    output logic [3:0]  state_dbg
);

    typedef enum logic [3:0] {
        S_IDLE, S_REQ, S_ACT, S_TRCD, S_RW, S_DATA, S_BST, S_PRE, S_TRP, S_DONE
    } state_t;

    // {RAS_N, CAS_N, WE_N}
    localparam logic [2:0] CMD_NOP = 3'b111;
    localparam logic [2:0] CMD_ACT = 3'b011;
    localparam logic [2:0] CMD_RD  = 3'b101;
    localparam logic [2:0] CMD_WR  = 3'b100;
    localparam logic [2:0] CMD_BST = 3'b110;
    localparam logic [2:0] CMD_PRE = 3'b010;

    // The ACT and PRE cycles themselves count as the first wait cycle.
    localparam logic [7:0] TRCD_LD = (T_RCD > 1) ? 8'(T_RCD - 2) : 8'd0;
    localparam logic [7:0] TRP_LD  = (T_RP  > 1) ? 8'(T_RP  - 2) : 8'd0;

    state_t       state_q, state_d;
    logic [7:0]   cnt_q, cnt_d;
    logic         wr_q;
    logic [1:0]   bank_q;
    logic [11:0]  row_q;
    logic [7:0]   col_q, len_q;
    logic         lat, abort;
    logic [7:0]   len_m1;
    logic [8:0]   len_eff;
    logic [8:0]   rv_left_q;
    logic         rd_done;
    logic         issue_q;
    logic [CAS_LAT-1:0] rd_pipe;

    logic [2:0]   cmd_d;
    logic [11:0]  sa_d;
    logic [1:0]   ba_d, dqm_d;
    logic         req_d, busy_d, done_d, err_d, wreq_d, oe_d, issue_d;

    assign len_m1     = len_q - 8'd1;              // 0 -> 255, i.e. 256 words
    assign len_eff    = (len_q == 8'd0) ? 9'd256 : {1'b0, len_q};
    // True once every expected rvalid has fired, counting one that fires now.
    assign rd_done    = (rv_left_q == 9'd0) || ((rv_left_q == 9'd1) && rvalid);
    assign dq_out     = wdata;
    assign CKE_accel  = 1'b1;
    assign CS_N_accel = 2'b00;
    assign state_dbg  = state_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        lat     = 1'b0;
        abort   = 1'b0;
        case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (start) begin
                    lat     = 1'b1;
                    state_d = S_REQ;
                end
            end
            S_REQ:  if (AccelHasControl) state_d = S_ACT;
            S_ACT: begin
                if (T_RCD > 1) begin
                    state_d = S_TRCD;
                    cnt_d   = TRCD_LD;
                end else begin
                    state_d = S_RW;
                end
            end
            S_TRCD: begin
                if (cnt_q == 8'd0) state_d = S_RW;
                else               cnt_d   = cnt_q - 8'd1;
            end
            S_RW: begin
                // The READ/WRITE cycle already covers the first word.
                if (len_m1 == 8'd0) begin
                    state_d = S_BST;
                end else begin
                    state_d = S_DATA;
                    cnt_d   = len_m1 - 8'd1;
                end
            end
            S_DATA: begin
                if (cnt_q == 8'd0) state_d = S_BST;
                else               cnt_d   = cnt_q - 8'd1;
            end
            S_BST: state_d = S_PRE;
            S_PRE: begin
                cnt_d = TRP_LD;
                if (T_RP == 1 && rd_done) state_d = S_DONE;
                else                      state_d = S_TRP;
            end
            S_TRP: begin
                if (cnt_q != 8'd0) cnt_d   = cnt_q - 8'd1;
                else if (rd_done)  state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase

        // Losing the grant while commands are in flight ends the transaction
        // with no precharge: the bus already belongs to someone else.
        if ((state_q inside {S_ACT, S_TRCD, S_RW, S_DATA, S_BST, S_PRE, S_TRP})
            && !AccelHasControl) begin
            abort   = 1'b1;
            state_d = S_DONE;
        end

        cmd_d   = CMD_NOP;
        sa_d    = 12'h000;
        ba_d    = 2'b00;
        dqm_d   = 2'b11;
        req_d   = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        err_d   = 1'b0;
        wreq_d  = 1'b0;
        oe_d    = 1'b0;
        issue_d = 1'b0;
        case (state_d)
            S_REQ, S_TRCD, S_TRP: begin
                req_d  = 1'b1;
                busy_d = 1'b1;
            end
            S_ACT: begin
                req_d  = 1'b1;
                busy_d = 1'b1;
                cmd_d  = CMD_ACT;
                sa_d   = row_q;
                ba_d   = bank_q;
            end
            S_RW, S_DATA: begin
                req_d   = 1'b1;
                busy_d  = 1'b1;
                dqm_d   = 2'b00;
                wreq_d  = wr_q;
                oe_d    = wr_q;
                issue_d = !wr_q;
                if (state_d == S_RW) begin
                    cmd_d = wr_q ? CMD_WR : CMD_RD;
                    sa_d  = {4'b0000, col_q};   // A10=0: no auto-precharge
                    ba_d  = bank_q;
                end
            end
            S_BST: begin
                req_d  = 1'b1;
                busy_d = 1'b1;
                cmd_d  = CMD_BST;
            end
            S_PRE: begin
                req_d  = 1'b1;
                busy_d = 1'b1;
                cmd_d  = CMD_PRE;
                sa_d   = 12'h400;               // A10=1: all banks
            end
            S_DONE: begin
                done_d = 1'b1;
                err_d  = abort;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge Reset_N) begin
        if (!Reset_N) begin
            state_q             <= S_IDLE;
            cnt_q               <= 8'd0;
            wr_q                <= 1'b0;
            bank_q              <= 2'b00;
            row_q               <= 12'h000;
            col_q               <= 8'd0;
            len_q               <= 8'd0;
            rv_left_q           <= 9'd0;
            issue_q             <= 1'b0;
            rd_pipe             <= '0;
            RequestAccelControl <= 1'b0;
            busy                <= 1'b0;
            done                <= 1'b0;
            err                 <= 1'b0;
            wreq                <= 1'b0;
            dq_oe               <= 1'b0;
            rvalid              <= 1'b0;
            rdata               <= 16'h0000;
            SA_accel            <= 12'h000;
            BA_accel            <= 2'b00;
            RAS_N_accel         <= 1'b1;
            CAS_N_accel         <= 1'b1;
            WE_N_accel          <= 1'b1;
            DQM_accel           <= 2'b11;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (lat) begin
                wr_q   <= wr;
                bank_q <= bank;
                row_q  <= row;
                col_q  <= col;
                len_q  <= len;
            end

            // Read data tracking runs apart from the command FSM. One bit per
            // issued read column walks through a CAS_LAT-deep pipe, then
            // flags the cycle the device drives that word.
            issue_q <= issue_d;
            if (abort) begin
                rd_pipe   <= '0;
                rvalid    <= 1'b0;
                rv_left_q <= 9'd0;
            end else begin
                rd_pipe <= (rd_pipe << 1) | CAS_LAT'(issue_q);
                rvalid  <= rd_pipe[CAS_LAT-1];
                if (rd_pipe[CAS_LAT-1]) rdata <= dq_in;
                if (state_d == S_RW && !wr_q) rv_left_q <= len_eff;
                else if (rvalid && rv_left_q != 9'd0) rv_left_q <= rv_left_q - 9'd1;
            end

            RequestAccelControl <= req_d;
            busy                <= busy_d;
            done                <= done_d;
            err                 <= err_d;
            wreq                <= wreq_d;
            dq_oe               <= oe_d;
            SA_accel            <= sa_d;
            BA_accel            <= ba_d;
            {RAS_N_accel, CAS_N_accel, WE_N_accel} <= cmd_d;
            DQM_accel           <= dqm_d;
        end
    end

endmodule
